// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM arbiter.
package sdram_arb_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 4;
  localparam int unsigned HOLD_W           = 4;
  localparam int unsigned DATA_W           = 32;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRdWait
  } arb_state_e;

  // True when the grant must be given up after the transaction just completed.
  function automatic logic release_grant(input logic [HOLD_W-1:0] hold_inc,
                                         input logic [HOLD_W-1:0] max_hold,
                                         input logic              other_req);
    return other_req || (hold_inc == max_hold);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: on a tie the requester that did not own last wins.
module arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_winner = 1'b0;
    case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = ~i_last;
      default: o_winner = 1'b0;
    endcase
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master SDRAM command arbiter: one-cycle arbitration, bounded grant hold,
// single outstanding read.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [DATA_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] sd_address,
  output logic              sd_read,
  output logic              sd_write,
  output logic [DATA_W-1:0] sd_writedata,
  input  logic              sd_waitrequest,
  input  logic [DATA_W-1:0] sd_readdata,
  input  logic              sd_readdatavalid
);

  localparam logic [HOLD_W-1:0] MaxHoldW = HOLD_W'(MAX_HOLD);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_last;
  logic [HOLD_W-1:0] r_hold;

  logic [1:0]        w_req;
  logic              w_win;
  logic              w_win_valid;
  logic              w_own_rd;
  logic              w_own_wr;
  logic              w_own_req;
  logic              w_oth_req;
  logic [DATA_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_release;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  arb_rr2 u_arb_rr2 (
    .i_req    (w_req),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_own_rd    = m0_read;
    w_own_wr    = m0_write;
    w_own_addr  = m0_address;
    w_own_wdata = m0_writedata;
    if (r_owner) begin
      w_own_rd    = m1_read;
      w_own_wr    = m1_write;
      w_own_addr  = m1_address;
      w_own_wdata = m1_writedata;
    end
  end

  assign w_own_req  = w_own_rd | w_own_wr;
  assign w_oth_req  = r_owner ? w_req[0] : w_req[1];
  assign w_hold_inc = r_hold + 4'd1;
  assign w_release  = release_grant(w_hold_inc, MaxHoldW, w_oth_req);

  // A read takes priority if a master illegally asserts read and write together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_hold  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_win_valid) begin
            r_state <= StGrant;
            r_owner <= w_win;
            r_hold  <= '0;
          end
        end
        StGrant: begin
          if (!w_own_req) begin
            r_state <= StIdle;
            r_last  <= r_owner;
          end else if (!sd_waitrequest) begin
            if (w_own_rd) begin
              r_state <= StRdWait;
            end else begin
              r_hold <= w_hold_inc;
              if (w_release) begin
                r_state <= StIdle;
                r_last  <= r_owner;
              end
            end
          end
        end
        StRdWait: begin
          if (sd_readdatavalid) begin
            r_hold <= w_hold_inc;
            if (w_release) begin
              r_state <= StIdle;
              r_last  <= r_owner;
            end else begin
              r_state <= StGrant;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Command path is a pure mux in GRANT so the owner sees SDRAM backpressure directly.
  always_comb begin
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    sd_address       = '0;
    sd_writedata     = '0;
    sd_read          = 1'b0;
    sd_write         = 1'b0;
    unique case (r_state)
      StGrant: begin
        sd_address   = w_own_addr;
        sd_writedata = w_own_wdata;
        sd_read      = w_own_rd;
        sd_write     = w_own_wr;
        if (r_owner) begin
          m1_waitrequest = sd_waitrequest;
        end else begin
          m0_waitrequest = sd_waitrequest;
        end
      end
      StRdWait: begin
        if (r_owner) begin
          m1_readdatavalid = sd_readdatavalid;
        end else begin
          m0_readdatavalid = sd_readdatavalid;
        end
      end
      default: ;
    endcase
  end

  assign m0_readdata = sd_readdata;
  assign m1_readdata = sd_readdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios plus a randomized two-master run checked by a scoreboard.
module tb_sdram_arbiter;

  localparam int MaxHold = 4;
  localparam int NumTxn  = 60;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  m_read, m_write, m_wait, m_rdv;
  logic [31:0] sd_address, sd_writedata, sd_readdata;
  logic        sd_read, sd_write, sd_waitrequest, sd_readdatavalid;

  int          errors = 0;
  int          checks = 0;
  cmd_t        cq0[$], cq1[$];
  logic [31:0] rq0[$], rq1[$];
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  bit          masters_done = 1'b0;
  bit          model_done   = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_address       (m_addr[0]),
    .m0_read          (m_read[0]),
    .m0_write         (m_write[0]),
    .m0_writedata     (m_wdata[0]),
    .m0_waitrequest   (m_wait[0]),
    .m0_readdata      (m_rdata[0]),
    .m0_readdatavalid (m_rdv[0]),
    .m1_address       (m_addr[1]),
    .m1_read          (m_read[1]),
    .m1_write         (m_write[1]),
    .m1_writedata     (m_wdata[1]),
    .m1_waitrequest   (m_wait[1]),
    .m1_readdata      (m_rdata[1]),
    .m1_readdatavalid (m_rdv[1]),
    .sd_address       (sd_address),
    .sd_read          (sd_read),
    .sd_write         (sd_write),
    .sd_writedata     (sd_writedata),
    .sd_waitrequest   (sd_waitrequest),
    .sd_readdata      (sd_readdata),
    .sd_readdatavalid (sd_readdatavalid)
  );

  function automatic void chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Expected per-cycle accept pattern for n back-to-back writes from a lone master.
  function automatic logic [15:0] hold_mask(input int n);
    logic [15:0] m;
    int pos;
    int rem;
    m   = '0;
    pos = 0;
    rem = n;
    while (rem > 0) begin
      int k;
      pos++;
      k = (rem > MaxHold) ? MaxHold : rem;
      for (int i = 0; i < k; i++) m[pos+i] = 1'b1;
      pos += k;
      rem -= k;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    m_read           = 2'b00;
    m_write          = 2'b00;
    m_addr[0]        = '0;
    m_addr[1]        = '0;
    m_wdata[0]       = '0;
    m_wdata[1]       = '0;
    sd_waitrequest   = 1'b0;
    sd_readdatavalid = 1'b0;
    sd_readdata      = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic master(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      int          gap;
      int          t;
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      we = 1'($urandom_range(0, 1));
      a  = (id == 0 ? 32'h1000 : 32'h2000) + 32'($urandom_range(0, 7)) * 4;
      d  = $urandom;
      m_addr[id]  = a;
      m_wdata[id] = d;
      m_read[id]  = ~we;
      m_write[id] = we;
      if (we) begin
        shadow[a] = d;
      end else if (id == 0) begin
        rq0.push_back(shadow.exists(a) ? shadow[a] : init_val(a));
      end else begin
        rq1.push_back(shadow.exists(a) ? shadow[a] : init_val(a));
      end
      if (id == 0) cq0.push_back({we, a, we ? d : 32'h0});
      else cq1.push_back({we, a, we ? d : 32'h0});
      t = 0;
      do begin
        sample();
        t++;
      end while (m_wait[id] !== 1'b0 && t < 200);
      if (m_wait[id] !== 1'b0) fail($sformatf("m%0d_accept_timeout", id), "waitrequest stuck high");
      step();
      m_read[id]  = 1'b0;
      m_write[id] = 1'b0;
    end
  endtask

  task automatic sdram_model();
    bit          pend;
    bit          new_rd;
    int          lat;
    int          guard;
    logic [31:0] raddr;
    pend   = 1'b0;
    new_rd = 1'b0;
    lat    = 0;
    guard  = 0;
    raddr  = '0;
    while ((!masters_done || pend) && guard < 5000) begin
      guard++;
      sample();
      if (sd_write && !sd_waitrequest) mem[sd_address] = sd_writedata;
      if (sd_read && !sd_waitrequest) begin
        new_rd = 1'b1;
        raddr  = sd_address;
      end
      step();
      sd_readdatavalid = 1'b0;
      sd_readdata      = $urandom;
      if (new_rd) begin
        pend   = 1'b1;
        new_rd = 1'b0;
        lat    = $urandom_range(0, 2);
      end
      if (pend) begin
        if (lat == 0) begin
          sd_readdatavalid = 1'b1;
          sd_readdata      = mem.exists(raddr) ? mem[raddr] : init_val(raddr);
          pend             = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        sd_readdatavalid = 1'b1;
      end
      sd_waitrequest = ($urandom_range(0, 3) == 0);
    end
    if (guard >= 5000) fail("sdram_model_timeout", "read never completed");
    step();
    sd_readdatavalid = 1'b0;
    sd_waitrequest   = 1'b0;
    step();
    model_done = 1'b1;
  endtask

  task automatic monitor();
    cmd_t got;
    cmd_t exp;
    while (!model_done) begin
      sample();
      if ((sd_read || sd_write) && !sd_waitrequest) begin
        got = {sd_write, sd_address, sd_write ? sd_writedata : 32'h0};
        if (m_wait == 2'b10) begin
          if (cq0.size() == 0) fail("cmd_m0_unexpected", "accepted command with none pending");
          else begin
            exp = cq0.pop_front();
            chk("cmd_m0", got, exp);
          end
        end else if (m_wait == 2'b01) begin
          if (cq1.size() == 0) fail("cmd_m1_unexpected", "accepted command with none pending");
          else begin
            exp = cq1.pop_front();
            chk("cmd_m1", got, exp);
          end
        end else begin
          fail("owner_unique", $sformatf("waitrequest=%b on accepted command", m_wait));
        end
      end
      if (m_rdv == 2'b11) fail("rdv_both", "both readdatavalid high");
      if (m_rdv[0]) begin
        if (rq0.size() == 0) fail("rdv_m0_unexpected", "readdatavalid=1 with no read outstanding");
        else chk("rdata_m0", m_rdata[0], rq0.pop_front());
      end
      if (m_rdv[1]) begin
        if (rq1.size() == 0) fail("rdv_m1_unexpected", "readdatavalid=1 with no read outstanding");
        else chk("rdata_m1", m_rdata[1], rq1.pop_front());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] mask;
    logic [15:0] exp_mask;
    int          sent;
    int          hi;
    bit          acc;
    bit          stable;

    // Reset holds IDLE outputs even with requests and a stray readdatavalid present.
    do_reset();
    rst_n            = 1'b0;
    m_read           = 2'b11;
    m_addr[0]        = 32'h44;
    m_addr[1]        = 32'h88;
    sd_readdatavalid = 1'b1;
    sd_readdata      = 32'h0000_FFFF;
    step();
    sample();
    chk("rst_wait", m_wait, 2'b11);
    chk("rst_sd_cmd", {sd_read, sd_write}, 2'b00);
    chk("rst_sd_addr", sd_address, 0);
    chk("rst_rdv", m_rdv, 2'b00);
    chk("rst_rdata_pass", m_rdata[1], 32'h0000_FFFF);

    // Single write, withdrawal, then a tie that must favour m1.
    do_reset();
    m_write[0] = 1'b1;
    m_addr[0]  = 32'h100;
    m_wdata[0] = 32'hDEADBEEF;
    sample();
    chk("wr_idle_wait", m_wait, 2'b11);
    chk("wr_idle_sdwr", sd_write, 1'b0);
    step();
    sample();
    chk("wr_sd_write", sd_write, 1'b1);
    chk("wr_sd_addr", sd_address, 32'h100);
    chk("wr_sd_data", sd_writedata, 32'hDEADBEEF);
    chk("wr_wait", m_wait, 2'b10);
    step();
    m_write[0] = 1'b0;
    sample();
    chk("wr_withdrawn", sd_write, 1'b0);
    step();
    m_write    = 2'b11;
    m_addr[0]  = 32'h200;
    m_addr[1]  = 32'h300;
    sample();
    chk("tie_idle_wait", m_wait, 2'b11);
    step();
    sample();
    chk("tie_m1_first_wait", m_wait, 2'b01);
    chk("tie_m1_first_addr", sd_address, 32'h300);
    step();
    m_write[1] = 1'b0;
    step();
    sample();
    chk("tie_m0_second_wait", m_wait, 2'b10);
    chk("tie_m0_second_addr", sd_address, 32'h200);
    step();
    m_write[0] = 1'b0;
    step();

    // Simultaneous reads after reset: m0 first, m1 after m0's data returns.
    do_reset();
    m_read    = 2'b11;
    m_addr[0] = 32'h40;
    m_addr[1] = 32'h80;
    step();
    sample();
    chk("rd_m0_grant", {m_wait, sd_read}, 3'b101);
    chk("rd_m0_addr", sd_address, 32'h40);
    step();
    m_read[0]        = 1'b0;
    sd_readdatavalid = 1'b1;
    sd_readdata      = 32'hCAFEF00D;
    sample();
    chk("rd_m0_rdv", m_rdv, 2'b01);
    chk("rd_m0_rdata", m_rdata[0], 32'hCAFEF00D);
    chk("rd_rdwait_wait", {m_wait, sd_read}, 3'b110);
    step();
    sd_readdatavalid = 1'b0;
    sample();
    chk("rd_rearb_wait", m_wait, 2'b11);
    step();
    sample();
    chk("rd_m1_grant", {m_wait, sd_read}, 3'b011);
    chk("rd_m1_addr", sd_address, 32'h80);
    step();
    m_read[1]   = 1'b0;
    sd_readdata = 32'h12345678;
    sample();
    chk("rd_m1_not_yet", m_rdv, 2'b00);
    step();
    sd_readdatavalid = 1'b1;
    sample();
    chk("rd_m1_rdv", m_rdv, 2'b10);
    chk("rd_m1_rdata", m_rdata[1], 32'h12345678);
    step();
    sd_readdatavalid = 1'b0;
    sample();
    chk("rd_m1_rdv_drop", m_rdv, 2'b00);
    step();
    step();

    // Lone master streaming six writes is cut after MaxHold.
    do_reset();
    sent = 0;
    mask = '0;
    for (int c = 0; c < 12; c++) begin
      m_write[0] = (sent < 6);
      m_addr[0]  = 32'h1000 + 32'(sent) * 4;
      sample();
      acc = sd_write && !sd_waitrequest && !m_wait[0];
      if (acc) mask[c] = 1'b1;
      step();
      if (acc) sent++;
    end
    exp_mask = hold_mask(6);
    chk("hold_pattern", mask, exp_mask);
    chk("hold_count", sent, 6);

    // m1 arriving mid-stream takes over after m0's current write.
    do_reset();
    m_write[0] = 1'b1;
    m_addr[0]  = 32'hA0;
    step();
    sample();
    chk("mid_m0_first", m_wait, 2'b10);
    step();
    m_addr[0]  = 32'hA4;
    m_write[1] = 1'b1;
    m_addr[1]  = 32'hB0;
    sample();
    chk("mid_m0_second", m_wait, 2'b10);
    step();
    m_addr[0] = 32'hA8;
    sample();
    chk("mid_idle", {m_wait, sd_write}, 3'b110);
    step();
    sample();
    chk("mid_m1_grant", m_wait, 2'b01);
    chk("mid_m1_addr", sd_address, 32'hB0);
    step();
    m_write = 2'b00;
    step();
    step();

    // Backpressure: m1 stalls for three cycles with the command held steady.
    do_reset();
    m_write[1]     = 1'b1;
    m_addr[1]      = 32'h500;
    m_wdata[1]     = 32'h55AA33CC;
    sd_waitrequest = 1'b1;
    step();
    hi     = 0;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      if (m_wait[1] === 1'b1) hi++;
      if (sd_address !== 32'h500 || sd_writedata !== 32'h55AA33CC || sd_write !== 1'b1)
        stable = 1'b0;
      step();
    end
    sd_waitrequest = 1'b0;
    sample();
    chk("bp_stall_cycles", hi, 3);
    chk("bp_stable", stable, 1'b1);
    chk("bp_accept", {m_wait, sd_write}, 3'b011);
    step();
    m_write[1] = 1'b0;
    step();

    // Reset while a read is outstanding drops the late return.
    do_reset();
    m_read[0] = 1'b1;
    m_addr[0] = 32'h60;
    step();
    step();
    m_read[0] = 1'b0;
    rst_n     = 1'b0;
    step();
    rst_n            = 1'b1;
    sd_readdatavalid = 1'b1;
    sd_readdata      = 32'hBAD0BAD0;
    sample();
    chk("rstrd_rdv", m_rdv, 2'b00);
    chk("rstrd_idle", {m_wait, sd_read, sd_write}, 4'b1100);
    chk("rstrd_addr", sd_address, 0);
    step();
    sd_readdatavalid = 1'b0;
    step();

    // Randomized two-master traffic against the scoreboard.
    do_reset();
    fork
      begin
        fork
          master(0, NumTxn);
          master(1, NumTxn);
        join
        masters_done = 1'b1;
      end
      sdram_model();
      monitor();
    join
    chk("cq0_drained", cq0.size(), 0);
    chk("cq1_drained", cq1.size(), 0);
    chk("rq0_drained", rq0.size(), 0);
    chk("rq1_drained", rq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, range 1..15: max consecutive transactions one requester keeps the grant while the other is idle.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 m0_address/m1_address  in  32  requester byte address.
REQ-005 m0_read/m1_read, m0_write/m1_write  in  1  requester command strobes, held until accepted.
REQ-006 m0_writedata/m1_writedata  in  32  requester write data.
REQ-007 m0_waitrequest/m1_waitrequest  out  1  stall to requester.
REQ-008 m0_readdata/m1_readdata  out  32  read return data.
REQ-009 m0_readdatavalid/m1_readdatavalid  out  1  read return qualifier.
REQ-010 sd_address  out  32; sd_read, sd_write  out  1; sd_writedata  out  32: SDRAM-facing command.
REQ-011 sd_waitrequest, sd_readdatavalid  in  1; sd_readdata  in  32: SDRAM-facing response.

Function
REQ-012 States: IDLE, GRANT, RDWAIT; registers owner (1 bit), last (1 bit, last owner), hold (4 bits).
REQ-013 IDLE: both m*_waitrequest=1, sd_read=sd_write=0, sd_address=sd_writedata=0, m*_readdatavalid=0.
REQ-014 IDLE, request = read|write: one requester -> it wins; both -> winner is !last; next state GRANT, owner=winner, hold=0; arbitration costs exactly one cycle.
REQ-015 GRANT: sd_address/sd_read/sd_write/sd_writedata combinationally equal owner's inputs; owner waitrequest = sd_waitrequest; non-owner waitrequest=1.
REQ-016 Accepted command = GRANT & (sd_read|sd_write) & !sd_waitrequest; m*_read and m*_write both high is illegal, unchecked.
REQ-017 Accepted write: hold+1; if other requester requesting or hold+1==MAX_HOLD -> IDLE, last=owner; else stay GRANT.
REQ-018 Accepted read: -> RDWAIT; one outstanding read only.
REQ-019 RDWAIT: sd_read=sd_write=0, both waitrequest=1; on sd_readdatavalid apply REQ-017 release rule (hold+1) in same cycle.
REQ-020 Both m*_readdata = sd_readdata always; m*_readdatavalid = sd_readdatavalid only for owner, only in RDWAIT; else 0.
REQ-021 GRANT with owner read=write=0 (request withdrawn): -> IDLE next cycle, last=owner, no command issued.
REQ-022 sd_readdatavalid in IDLE or GRANT: ignored, never forwarded.
REQ-023 Release and re-request same cycle: owner must re-arbitrate in IDLE; never holds grant across IDLE.

Reset
REQ-024 rst_n low at a clock edge: state=IDLE, owner=0, last=1 (requester 0 wins first tie), hold=0; outputs take REQ-013 values next cycle.
REQ-025 Reset mid-GRANT or RDWAIT abandons transaction; a late sd_readdatavalid is dropped per REQ-022.

Structure
REQ-026 Package sdram_arb_pkg holds state enum and MAX_HOLD default.
REQ-027 Sub-module arb_rr2: 2-input round-robin picker (req[1:0], last -> winner, valid); rest in sdram_arbiter.

Verification
REQ-028 Single write: m0 write addr 0x100 data 0xDEADBEEF, sd_waitrequest=0 -> sd_write high with those values the cycle after m0 asserts, m0_waitrequest low that cycle, return to IDLE with last=0.
REQ-029 Tie: m0, m1 reads same cycle after reset -> m0 granted first; m1 granted after m0's readdatavalid; m1 readdata 0x12345678 seen only on m1_readdatavalid.
REQ-030 Hold: m0 streams 6 writes, m1 idle, MAX_HOLD=4 -> 4 writes, one IDLE cycle, then 2 more; m1 requesting mid-stream -> grant to m1 after m0's current write.
REQ-031 Backpressure: sd_waitrequest high 3 cycles during m1 write -> m1_waitrequest high 3 cycles, address/data stable, accept on 4th.
REQ-032 Reset in RDWAIT, then sd_readdatavalid next cycle -> no m*_readdatavalid pulse; IDLE outputs.
